// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//
// Power-up and recovery sequencer for the system PLL. Holds the PLL in reset
// for a fixed number of reference cycles, waits for a lock indication that
// stays stable, and only then releases the reset of the logic clocked by the
// PLL output. Loss of lock or a software request restarts the sequence. Lock
// timeouts are retried a bounded number of times before the block parks in
// FAIL.
//
// Ports
//   refclk     in   1  free-running reference clock (sole clock)
//   rst_n      in   1  asynchronous active-low reset
//   pll_locked in   1  PLL lock output, asynchronous to refclk
//   sw_relock  in   1  one-cycle request to restart the sequence
//   pll_rst    out  1  active-high reset to the PLL
//   sys_rst_n  out  1  active-low reset to the PLL-clocked domain
//   ready      out  1  high only in RUN
//   fail       out  1  high only in FAIL
//   retry_cnt  out  2  failed lock attempts in the current sequence
//   state_dbg  out  3  0 RESET, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAIL
// -----------------------------------------------------------------------------
module pll_lock_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES     = 100,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 16
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sw_relock,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [1:0] retry_cnt,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic [1:0]       retry_inc;
  logic [1:0]       sync_q;
  logic             lk_s;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;

  // Two-flop synchronizer for the asynchronous lock indication.
  // NOTE: sequential state is written with <= only; blocking assignments here
  // would let the second flop see the first flop's new value in the same edge
  // and collapse the synchronizer to a single stage.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  assign lk_s = sync_q[1];

  // Saturating increment so a stray extra timeout cannot wrap the count.
  assign retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + 2'd1;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;

    if (sw_relock) begin
      // Highest priority: overrides any timeout, lock or lock-loss event.
      state_d = ST_RESET;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lk_s) begin
            state_d = ST_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_RESET;
          end
        end
        ST_STABLE: begin
          // Any low sample restarts the lock wait without counting a retry.
          if (!lk_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            retry_d = '0;
          end
        end
        ST_RUN: begin
          retry_d = '0;
          if (!lk_s) state_d = ST_RESET;
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_RESET;
          retry_d = '0;
        end
      endcase
    end

    // The counter only measures time within a state: it restarts on every
    // state change, on a relock request, and idles at zero in RUN and FAIL.
    if (sw_relock || (state_d != state_q) || (state_d == ST_RUN) ||
        (state_d == ST_FAIL)) begin
      cnt_d = '0;
    end

    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as the state they describe.
    pll_rst_d   = (state_d == ST_RESET) || (state_d == ST_FAIL);
    sys_rst_n_d = (state_d == ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
//
// Directed bench for pll_lock_sequencer with small cycle parameters. The
// stimulus thread queues the expected sequence of output changes (state,
// derived output levels, retry count and the number of cycles spent in the
// previous state). A monitor samples outputs on the falling edge and, every
// time the output vector changes, pops and compares one expected entry.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

  localparam logic [2:0] ST_RESET = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_STAB  = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_FAIL  = 3'd4;

  logic       refclk     = 1'b0;
  logic       rst_n      = 1'b0;
  logic       pll_locked = 1'b0;
  logic       sw_relock  = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [2:0] state_dbg;

  always #5 refclk = ~refclk;

  pll_lock_sequencer #(
    .RST_HOLD_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES(20),
    .LOCK_STABLE_CYCLES (8),
    .MAX_RETRIES        (2),
    .CNT_W              (16)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .sw_relock (sw_relock),
    .pll_rst   (pll_rst),
    .sys_rst_n (sys_rst_n),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .state_dbg (state_dbg)
  );

  typedef struct {
    logic [8:0] vec;    // {state, pll_rst, sys_rst_n, ready, fail, retry_cnt}
    int         dwell;  // cycles in the previous state, -1 = not checked
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   cyc     = 0;
  int   last_ev = 0;

  always @(posedge refclk) cyc = cyc + 1;

  // A reset release is the time origin for the first hold count.
  always @(posedge rst_n) last_ev = cyc;

  function automatic logic [8:0] pack(input logic [2:0] st, input logic [1:0] rc);
    logic run;
    logic flt;
    run = (st == ST_RUN);
    flt = (st == ST_FAIL);
    return {st, (st == ST_RESET) || flt, run, run, flt, rc};
  endfunction

  task automatic expect_ev(input logic [2:0] st, input logic [1:0] rc, input int dw);
    exp_t e;
    e.vec   = pack(st, rc);
    e.dwell = dw;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge refclk);
      #2;
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge refclk);
      #2;
      if (state_dbg == st) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL wait_state: state %0d not reached in %0d cycles, got %0d",
             st, max_cyc, state_dbg);
  endtask

  // Monitor: every change of the output vector is one observed event.
  logic [8:0] prev = 'x;
  always @(negedge refclk) begin : monitor
    logic [8:0] cur;
    exp_t       e;
    int         dw;
    cur = {state_dbg, pll_rst, sys_rst_n, ready, fail, retry_cnt};
    if (cur !== prev) begin
      dw      = cyc - last_ev;
      last_ev = cyc;
      prev    = cur;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: got out=%b at cycle %0d, no change required",
                 cur, cyc);
      end else begin
        e = exp_q.pop_front();
        if ((cur !== e.vec) || ((e.dwell >= 0) && (dw != e.dwell))) begin
          n_err++;
          $display("FAIL event: got out=%b dwell=%0d, required out=%b dwell=%0d",
                   cur, dw, e.vec, e.dwell);
        end
      end
    end
  end

  initial begin
    // Reset state, observed while rst_n is held low.
    expect_ev(ST_RESET, 2'd0, -1);
    step(3);
    check("reset_pll_rst", 32'(pll_rst), 32'd1);
    check("reset_sys_rst_n", 32'(sys_rst_n), 32'd0);
    check("reset_state", 32'(state_dbg), 32'(ST_RESET));

    // 1: power-up with lock arriving during WAIT_LOCK.
    expect_ev(ST_WAIT, 2'd0, 4);
    expect_ev(ST_STAB, 2'd0, 8);
    expect_ev(ST_RUN,  2'd0, 8);
    rst_n = 1'b1;
    wait_state(ST_WAIT, 10);
    step(5);
    pll_locked = 1'b1;
    wait_state(ST_RUN, 40);

    // 3: single-cycle lock drop in RUN forces a full resequence.
    expect_ev(ST_RESET, 2'd0, 6);
    expect_ev(ST_WAIT,  2'd0, 4);
    expect_ev(ST_STAB,  2'd0, 1);
    expect_ev(ST_RUN,   2'd0, 8);
    step(3);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    wait_state(ST_RESET, 10);
    wait_state(ST_RUN, 40);

    // 4: relock from RUN, then a glitch in STABLE at cnt=5 (no retry counted).
    expect_ev(ST_RESET, 2'd0, 3);
    expect_ev(ST_WAIT,  2'd0, 4);
    expect_ev(ST_STAB,  2'd0, 1);
    expect_ev(ST_WAIT,  2'd0, 6);
    expect_ev(ST_STAB,  2'd0, 1);
    expect_ev(ST_RUN,   2'd0, 8);
    step(2);
    sw_relock = 1'b1;
    step(1);
    sw_relock = 1'b0;
    wait_state(ST_STAB, 20);
    step(3);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    wait_state(ST_RUN, 40);

    // 2: lock lost for good; two timeouts lead to FAIL, which must hold.
    expect_ev(ST_RESET, 2'd0, 3);
    expect_ev(ST_WAIT,  2'd0, 4);
    expect_ev(ST_RESET, 2'd1, 20);
    expect_ev(ST_WAIT,  2'd1, 4);
    expect_ev(ST_FAIL,  2'd2, 20);
    pll_locked = 1'b0;
    wait_state(ST_FAIL, 100);
    step(120);
    check("fail_hold_state", 32'(state_dbg), 32'(ST_FAIL));
    check("fail_hold_flag", 32'(fail), 32'd1);
    check("fail_hold_pll_rst", 32'(pll_rst), 32'd1);
    check("fail_hold_retry", 32'(retry_cnt), 32'd2);

    // 5: relock out of FAIL with lock present.
    expect_ev(ST_RESET, 2'd0, 126);
    expect_ev(ST_WAIT,  2'd0, 4);
    expect_ev(ST_STAB,  2'd0, 1);
    expect_ev(ST_RUN,   2'd0, 8);
    pll_locked = 1'b1;
    step(5);
    sw_relock = 1'b1;
    step(1);
    sw_relock = 1'b0;
    check("relock_state", 32'(state_dbg), 32'(ST_RESET));
    check("relock_retry", 32'(retry_cnt), 32'd0);
    check("relock_fail", 32'(fail), 32'd0);
    wait_state(ST_RUN, 40);

    // 6: relock coincident with the timeout, relock inside RESET, then an
    //    asynchronous reset pulse in STABLE.
    expect_ev(ST_RESET, 2'd0, 3);
    expect_ev(ST_WAIT,  2'd0, 4);
    expect_ev(ST_RESET, 2'd0, 20);
    expect_ev(ST_WAIT,  2'd0, 7);
    expect_ev(ST_STAB,  2'd0, 1);
    expect_ev(ST_RESET, 2'd0, -1);
    expect_ev(ST_WAIT,  2'd0, 4);
    expect_ev(ST_STAB,  2'd0, 1);
    expect_ev(ST_RUN,   2'd0, 8);
    pll_locked = 1'b0;
    wait_state(ST_WAIT, 20);
    step(19);
    sw_relock = 1'b1;
    step(1);
    sw_relock = 1'b0;
    step(2);
    sw_relock = 1'b1;
    step(1);
    sw_relock  = 1'b0;
    pll_locked = 1'b1;
    wait_state(ST_STAB, 20);
    step(2);
    rst_n = 1'b0;
    #1;
    check("async_state", 32'(state_dbg), 32'(ST_RESET));
    check("async_pll_rst", 32'(pll_rst), 32'd1);
    check("async_sys_rst_n", 32'(sys_rst_n), 32'd0);
    check("async_ready", 32'(ready), 32'd0);
    check("async_fail", 32'(fail), 32'd0);
    check("async_retry", 32'(retry_cnt), 32'd0);
    step(2);
    rst_n = 1'b1;
    wait_state(ST_RUN, 40);
    step(5);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
